// File: rtl/led_pulse_stretcher_pkg.sv
// Shared definitions for the LED pulse stretcher: FSM state encoding and
// duration-counter width.
package led_pulse_stretcher_pkg;

  localparam int unsigned DUR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

endpackage

// File: rtl/led_pulse_stretcher_sat_updown_counter.sv
// Saturating up/down counter: holds at all-ones on increment and at zero on
// decrement; a simultaneous inc and dec leaves the count unchanged.
module sat_updown_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-length LED blinks with a
// mandatory off gap; events arriving mid-blink are queued in a pending counter.
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 5000000,
  parameter int unsigned OFF_CYCLES = 5000000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [DUR_W-1:0] ON_LAST  = DUR_W'(ON_CYCLES - 1);
  localparam logic [DUR_W-1:0] OFF_LAST = DUR_W'(OFF_CYCLES - 1);

  state_t           state, state_d;
  logic [DUR_W-1:0] dur;
  logic             on_last, off_last, pend_nz;
  logic             inc, dec, sat;
  logic             led_d, busy_d, overflow_d;

  assign on_last  = (state == ST_ON)  && (dur == ON_LAST);
  assign off_last = (state == ST_OFF) && (dur == OFF_LAST);
  assign pend_nz  = |pending;

  // State register, duration counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dur      <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      dur      <= ((state_d != state) || (state_d == ST_IDLE)) ? '0 : dur + DUR_W'(1);
      led      <= led_d;
      busy     <= busy_d;
      overflow <= overflow_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (pulse_in) state_d = ST_ON;
      ST_ON:   if (on_last)  state_d = ST_OFF;
      ST_OFF:  if (off_last) state_d = (pend_nz || pulse_in) ? ST_ON : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // On the last OFF cycle with nothing pending, a strobe starts the next blink
  // directly instead of passing through the counter.
  always_comb begin
    inc = pulse_in && ((state == ST_ON) ||
                       ((state == ST_OFF) && (!off_last || pend_nz)));
    dec = off_last && pend_nz;
  end

  // IDLE is only reachable with pending at zero, so busy follows the next state.
  always_comb begin
    led_d      = (state_d == ST_ON);
    busy_d     = (state_d != ST_IDLE);
    overflow_d = inc && !dec && sat;
  end

  sat_updown_counter #(
    .W(PEND_W)
  ) u_pending (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .dec  (dec),
    .count(pending),
    .sat  (sat)
  );

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
// Each step checks {led, busy, pending, overflow} one delta after the clock edge.
module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       led, busy, overflow;
  logic [1:0] pending;

  int unsigned total = 0;
  int unsigned bad   = 0;

  led_pulse_stretcher #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .PEND_W    (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drive inputs for the current cycle, clock once, check the next cycle's outputs.
  task automatic step(input logic r, input logic p, input logic [4:0] exp, input string tag);
    logic [4:0] obs;
    rst      = r;
    pulse_in = p;
    @(posedge clk);
    #1;
    obs = {led, busy, pending, overflow};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed led,busy,pend,ovf=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_steps(input int n, input logic [4:0] exp, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, exp, tag);
  endtask

  initial begin
    // Reset, with a strobe that must be ignored
    step(1'b1, 1'b1, 5'b0_0_00_0, "reset_pulse_ignored");
    step(1'b1, 1'b0, 5'b0_0_00_0, "reset_hold");

    // Single pulse
    step(1'b0, 1'b1, 5'b1_1_00_0, "single_on_c1");
    idle_steps(3, 5'b1_1_00_0, "single_on");
    idle_steps(3, 5'b0_1_00_0, "single_off");
    idle_steps(2, 5'b0_0_00_0, "single_idle");

    // Three consecutive pulses
    step(1'b0, 1'b1, 5'b1_1_00_0, "three_c1");
    step(1'b0, 1'b1, 5'b1_1_01_0, "three_c2");
    step(1'b0, 1'b1, 5'b1_1_10_0, "three_c3");
    idle_steps(1, 5'b1_1_10_0, "three_on1");
    idle_steps(3, 5'b0_1_10_0, "three_off1");
    idle_steps(4, 5'b1_1_01_0, "three_on2");
    idle_steps(3, 5'b0_1_01_0, "three_off2");
    idle_steps(4, 5'b1_1_00_0, "three_on3");
    idle_steps(3, 5'b0_1_00_0, "three_off3");
    idle_steps(1, 5'b0_0_00_0, "three_idle");

    // Saturation: pending tops out at 3, two drops each strobe overflow
    step(1'b0, 1'b1, 5'b1_1_00_0, "sat_c1");
    step(1'b0, 1'b1, 5'b1_1_01_0, "sat_c2");
    step(1'b0, 1'b1, 5'b1_1_10_0, "sat_c3");
    step(1'b0, 1'b1, 5'b1_1_11_0, "sat_c4");
    step(1'b0, 1'b1, 5'b0_1_11_1, "sat_drop1");
    step(1'b0, 1'b0, 5'b0_1_11_0, "sat_ovf_clear");
    step(1'b0, 1'b1, 5'b0_1_11_1, "sat_drop2");
    step(1'b0, 1'b0, 5'b1_1_10_0, "sat_on2_start");
    idle_steps(3, 5'b1_1_10_0, "sat_on2");
    idle_steps(3, 5'b0_1_10_0, "sat_off2");
    idle_steps(4, 5'b1_1_01_0, "sat_on3");
    idle_steps(3, 5'b0_1_01_0, "sat_off3");
    idle_steps(4, 5'b1_1_00_0, "sat_on4");
    idle_steps(3, 5'b0_1_00_0, "sat_off4");
    idle_steps(2, 5'b0_0_00_0, "sat_idle");

    // Pulse on last OFF cycle with nothing pending
    step(1'b0, 1'b1, 5'b1_1_00_0, "lastoff0_c1");
    idle_steps(3, 5'b1_1_00_0, "lastoff0_on1");
    idle_steps(3, 5'b0_1_00_0, "lastoff0_off1");
    step(1'b0, 1'b1, 5'b1_1_00_0, "lastoff0_direct_on");
    idle_steps(3, 5'b1_1_00_0, "lastoff0_on2");
    idle_steps(3, 5'b0_1_00_0, "lastoff0_off2");
    idle_steps(1, 5'b0_0_00_0, "lastoff0_idle");

    // Pulse on last OFF cycle with two pending, then reset in second ON cycle
    step(1'b0, 1'b1, 5'b1_1_00_0, "lastoff2_c1");
    step(1'b0, 1'b1, 5'b1_1_01_0, "lastoff2_c2");
    step(1'b0, 1'b1, 5'b1_1_10_0, "lastoff2_c3");
    idle_steps(1, 5'b1_1_10_0, "lastoff2_on1");
    idle_steps(3, 5'b0_1_10_0, "lastoff2_off1");
    step(1'b0, 1'b1, 5'b1_1_10_0, "lastoff2_hold");
    idle_steps(1, 5'b1_1_10_0, "lastoff2_on_c2");
    step(1'b1, 1'b0, 5'b0_0_00_0, "midblink_reset");
    idle_steps(10, 5'b0_0_00_0, "post_reset_quiet");

    // Reset with strobe, then strobe in first cycle after release
    step(1'b1, 1'b1, 5'b0_0_00_0, "reset_pulse_ignored2");
    step(1'b0, 1'b1, 5'b1_1_00_0, "first_after_reset");
    idle_steps(3, 5'b1_1_00_0, "after_reset_on");
    idle_steps(3, 5'b0_1_00_0, "after_reset_off");
    idle_steps(1, 5'b0_0_00_0, "after_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
